sim_bus_arb: RTL

// - Parametrised simulation interconnect for Ibex test tops: NrHosts hosts to NrDevices devices over the Ibex req/gnt/rvalid protocol.
// - Successor to the fixed-priority single-outstanding bus: adds selectable round-robin arbitration and up to MaxOutstanding in-flight requests.
// - Adds an internal error responder for unmapped addresses.

---
 rtl/sim_bus_pkg.sv | 11 +
 rtl/sim_bus_resp_fifo.sv | 61 ++++++
 rtl/sim_bus_arb.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sim_bus_pkg.sv
// Shared types and constants for the simulation bus interconnect.
package sim_bus_pkg;

  typedef enum logic {
    ArbFixed,
    ArbRoundRobin
  } arb_mode_e;

  localparam int unsigned PerfCntWidth = 32;

endpackage

// File: rtl/sim_bus_resp_fifo.sv
// In-order response tracking FIFO. The head is only visible the cycle after a push,
// and a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sim_bus_resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = ptr_inc(wptr_q);
    if (pop_ok)  rptr_d = ptr_inc(rptr_q);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CntW'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sim_bus_arb.sv
// NrHosts-to-NrDevices simulation interconnect with fixed or round-robin arbitration,
// in-order response tracking and a decode-error responder. SIM_BUS_ARB_PERF_EN adds counters.
module sim_bus_arb
  import sim_bus_pkg::*;
#(
  parameter int unsigned NrHosts        = 3,
  parameter int unsigned NrDevices      = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter arb_mode_e   ArbMode        = ArbRoundRobin
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      host_req_i             [NrHosts],
  output logic                      host_gnt_o             [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i            [NrHosts],
  input  logic                      host_we_i              [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i              [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i           [NrHosts],
  output logic                      host_rvalid_o          [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o           [NrHosts],
  output logic                      host_err_o             [NrHosts],
  output logic                      device_req_o           [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o          [NrDevices],
  output logic                      device_we_o            [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o            [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o         [NrDevices],
  input  logic                      device_rvalid_i        [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i         [NrDevices],
  input  logic                      device_err_i           [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_base_i [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask_i [NrDevices],
  output logic [PerfCntWidth-1:0]   perf_gnt_cnt_o         [NrHosts],
  output logic [PerfCntWidth-1:0]   perf_stall_cnt_o
);

  localparam int unsigned HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  typedef struct packed {
    logic [HostW-1:0] host;
    logic [DevW-1:0]  dev;
    logic             dec_err;
  } entry_t;

  logic [HostW-1:0] rr_q, rr_d, win_idx, cand;
  logic [DevW-1:0]  dev_idx;
  logic             any_req, dec_hit;
  logic             fifo_full, fifo_empty, push, pop;
  entry_t           push_entry, head;

  // Arbitration: search from rr_q upward with wrap, or from 0 in fixed mode.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      if (ArbMode == ArbRoundRobin) cand = HostW'((32'(rr_q) + i) % NrHosts);
      else                          cand = HostW'(i);
      if (host_req_i[cand] && !any_req) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    dec_hit = 1'b0;
    dev_idx = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dec_hit &&
          ((host_addr_i[win_idx] & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d])) begin
        dec_hit = 1'b1;
        dev_idx = DevW'(d);
      end
    end
  end

  // Decode-error entries complete the first cycle they reach the head.
  assign pop  = !fifo_empty && (head.dec_err || device_rvalid_i[head.dev]);
  assign push = rst_ni && any_req && (!fifo_full || pop);
  assign push_entry = '{host: win_idx, dev: dev_idx, dec_err: !dec_hit};

  assign rr_d = (push && (ArbMode == ArbRoundRobin)) ?
                ((win_idx == HostW'(NrHosts - 1)) ? '0 : win_idx + HostW'(1)) : rr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  sim_bus_resp_fifo #(
    .Width($bits(entry_t)),
    .Depth(MaxOutstanding)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_gnt_o[h]    = push && (win_idx == HostW'(h));
      host_rvalid_o[h] = pop && (head.host == HostW'(h));
      host_rdata_o[h]  = (host_rvalid_o[h] && !head.dec_err) ? device_rdata_i[head.dev] : '0;
      host_err_o[h]    = host_rvalid_o[h] && (head.dec_err || device_err_i[head.dev]);
    end
  end

  always_comb begin
    for (int unsigned d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = push && dec_hit && (dev_idx == DevW'(d));
      device_addr_o[d]  = host_addr_i[win_idx];
      device_we_o[d]    = host_we_i[win_idx];
      device_be_o[d]    = host_be_i[win_idx];
      device_wdata_o[d] = host_wdata_i[win_idx];
    end
  end

`ifdef SIM_BUS_ARB_PERF_EN
  logic [PerfCntWidth-1:0] gnt_cnt_q [NrHosts];
  logic [PerfCntWidth-1:0] stall_cnt_q;
  logic                    stall;

  assign stall = any_req && fifo_full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned h = 0; h < NrHosts; h++) gnt_cnt_q[h] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned h = 0; h < NrHosts; h++) begin
        if (host_gnt_o[h] && (gnt_cnt_q[h] != '1)) begin
          gnt_cnt_q[h] <= gnt_cnt_q[h] + PerfCntWidth'(1);
        end
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PerfCntWidth'(1);
    end
  end

  assign perf_gnt_cnt_o   = gnt_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) perf_gnt_cnt_o[h] = '0;
  end
  assign perf_stall_cnt_o = '0;
`endif

  // A device may only respond when it owns the head entry.
  for (genvar d = 0; d < NrDevices; d++) begin : g_proto_chk
    unexpected_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      device_rvalid_i[d] |-> (!fifo_empty && !head.dec_err && (head.dev == DevW'(d))));
  end

endmodule
